rf_wport_arbiter: RTL and testbench
===================================

# rf_wport_arbiter

- Shares the single register-file write port between two requesters:
  - the in-order pipeline writeback stage;
  - a decoupled long-latency result source (LR: multiplier/late-load return), over a valid/ready handshake.
- Sits between the writeback stage and the regfile, and drives the difftest debug trace.
- Pipeline has priority. A starvation counter can briefly freeze the pipeline so LR makes forward progress.
- The port write and trace outputs are registered.

## Interface
Parameters:
- STARVE_MAX, default 4: cycles LR may wait while losing to the pipeline before a forced grant (legal 1..15).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- wb_wen_i  input  1  pipeline write request.
- wb_waddr_i  input  5  pipeline destination register.
- wb_wdata_i  input  32  pipeline write data.
- wb_pc_i  input  32  pipeline instruction PC.
- wb_stall_i  input  1  WB stage stalled; its request is invalid this cycle.
- wb_flush_i  input  1  WB stage flushed; its request is invalid this cycle.
- lr_valid_i  input  1  LR request valid.
- lr_waddr_i  input  5  LR destination register.
- lr_wdata_i  input  32  LR write data.
- lr_pc_i  input  32  LR originating PC.
- lr_ready_o  output  1  LR granted this cycle (combinational).
- arb_stall_o  output  1  freeze request to the pipeline (combinational from state).
- rf_wen_o  output  1  registered regfile write enable.
- rf_waddr_o  output  5  registered write address.
- rf_wdata_o  output  32  registered write data.
- debug_wb_pc  output  32  PC of the write in rf_*.
- debug_wb_rf_wen  output  4  {4{rf_wen_o}}.
- debug_wb_rf_wnum  output  5  equals rf_waddr_o.
- debug_wb_rf_wdata  output  32  equals rf_wdata_o.

## Operation
- Valid pipeline request: pipe_req = wb_wen_i & ~wb_stall_i & ~wb_flush_i.
- State machine, two states: NORMAL and FORCE.
- NORMAL:
  - If pipe_req: grant pipe. lr_ready_o=0. If lr_valid_i, starve_cnt increments.
  - Else if lr_valid_i: grant LR. lr_ready_o=1, starve_cnt clears.
  - Else: no grant, rf_wen_o=0 next cycle. starve_cnt holds.
  - Enter FORCE when the pipe is granted, lr_valid_i=1 and starve_cnt==STARVE_MAX-1.
- FORCE:
  - arb_stall_o=1. Pipeline inputs are ignored; the pipeline holds its instruction.
  - LR is granted if lr_valid_i.
  - Always returns to NORMAL next cycle with starve_cnt=0.
- Handshake:
  - LR holds valid and payload stable until a cycle with lr_valid_i & lr_ready_o.
  - A transfer happens exactly on that cycle.
- Register $0 writes pass through unchanged; the regfile discards them.
- Grant mux selects the {wen, waddr, wdata, pc} tuple of the winner. No-grant loads wen=0; addr/data/pc hold.
- starve_cnt is 4 bits and saturates; it never wraps.

## Timing
- Reset, asynchronous on rst low:
  - state=NORMAL, starve_cnt=0.
  - rf_wen_o=0, rf_waddr_o=0, rf_wdata_o=0, debug_wb_pc=0, debug_wb_rf_wen=0.
  - lr_ready_o=0, arb_stall_o=0.
- Latency: a grant in cycle N appears on rf_* and debug_* in cycle N+1. Exactly one write per grant.
- Simultaneous pipe_req and lr_valid_i in NORMAL: the pipe wins unless the FORCE condition holds. Even then the pipe wins that cycle, and LR wins the next.
- Flush or stall on the same cycle as wb_wen_i: no pipe grant, and LR may take the slot.
- If lr_valid_i drops in FORCE (protocol violation): no write, and the state still returns to NORMAL.
- Reset asserted during FORCE: any pending LR transfer is lost, and the LR source must re-present after reset.
- Back-to-back grants are allowed every cycle, giving throughput of 1 write/cycle.

## Configuration
- RF_ARB_STARVE_EN defined: starve_cnt and the FORCE state are implemented as above.
- RF_ARB_STARVE_EN undefined:
  - strict pipeline priority with no counter and no FORCE state;
  - arb_stall_o is tied 0;
  - LR is granted only in cycles without pipe_req.

## Test plan
- Reset check: rst low mid-traffic → all outputs 0 immediately. After release, the first grant of wb_waddr_i=5, wb_wdata_i=0x1234 appears on rf_* one cycle later with debug_wb_rf_wen=4'hF.
- Pipe only: wb_wen_i=1 for 3 cycles with addr 1,2,3 → rf_waddr_o=1,2,3 in the following 3 cycles; lr_ready_o stays 0.
- LR in idle gap:
  - Pipe idle, lr_valid_i=1, lr_waddr_i=9, lr_wdata_i=0xDEAD, lr_pc_i=0xBFC00100.
  - lr_ready_o=1 that cycle.
  - Next cycle: rf_waddr_o=9, debug_wb_pc=0xBFC00100.
- Starvation (STARVE_MAX=4, macro on):
  - pipe_req and lr_valid_i are continuous.
  - The pipe wins 4 cycles.
  - Cycle 5: arb_stall_o=1, lr_ready_o=1.
  - Cycle 6: LR write on rf_*, arb_stall_o=0, and the pipe resumes.
- Flush/stall gating: wb_wen_i=1 with wb_flush_i=1, then wb_wen_i=1 with wb_stall_i=1, while lr_valid_i=0 → rf_wen_o=0 in both following cycles.
- Macro off: the same stimulus as the starvation test → arb_stall_o never asserts, and LR is granted only after pipe_req drops.

Source files
------------

// File: rtl/rf_wport_arbiter.sv
// rtl/rf_wport_arbiter.sv - register-file write-port arbiter between the WB stage and a long-latency result source
// Optional starvation guard (counter + FORCE state) is built when RF_ARB_STARVE_EN is defined.
module rf_wport_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_wen_i,
    input  logic [4:0]  wb_waddr_i,
    input  logic [31:0] wb_wdata_i,
    input  logic [31:0] wb_pc_i,
    input  logic        wb_stall_i,
    input  logic        wb_flush_i,
    input  logic        lr_valid_i,
    input  logic [4:0]  lr_waddr_i,
    input  logic [31:0] lr_wdata_i,
    input  logic [31:0] lr_pc_i,
    output logic        lr_ready_o,
    output logic        arb_stall_o,
    output logic        rf_wen_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
);

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("rf_wport_arbiter: STARVE_MAX must be in 1..15");
    end

    logic pipe_req;
    logic grant_pipe;
    logic grant_lr;

    assign pipe_req = wb_wen_i & ~wb_stall_i & ~wb_flush_i;

`ifdef RF_ARB_STARVE_EN
    typedef enum logic {ST_NORMAL, ST_FORCE} state_t;

    localparam logic [3:0] STARVE_LAST = 4'(STARVE_MAX - 1);

    state_t     state, state_nxt;
    logic [3:0] starve_cnt, starve_cnt_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_NORMAL;
            starve_cnt <= 4'd0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        starve_cnt_nxt = starve_cnt;
        grant_pipe     = 1'b0;
        grant_lr       = 1'b0;
        arb_stall_o    = 1'b0;
        case (state)
            ST_NORMAL: begin
                if (pipe_req) begin
                    grant_pipe = 1'b1;
                    if (lr_valid_i) begin
                        // Pipe still wins this cycle; LR is guaranteed the next one.
                        if (starve_cnt != 4'hF)
                            starve_cnt_nxt = starve_cnt + 4'd1;
                        if (starve_cnt == STARVE_LAST)
                            state_nxt = ST_FORCE;
                    end
                end else if (lr_valid_i) begin
                    grant_lr       = 1'b1;
                    starve_cnt_nxt = 4'd0;
                end
            end
            ST_FORCE: begin
                arb_stall_o    = 1'b1;
                grant_lr       = lr_valid_i;
                state_nxt      = ST_NORMAL;
                starve_cnt_nxt = 4'd0;
            end
        endcase
    end
`else
    assign grant_pipe  = pipe_req;
    assign grant_lr    = ~pipe_req & lr_valid_i;
    assign arb_stall_o = 1'b0;
`endif

    // Ready must read 0 while reset is held, even with LR presenting.
    assign lr_ready_o = grant_lr & rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_wen_o    <= 1'b0;
            rf_waddr_o  <= 5'd0;
            rf_wdata_o  <= 32'd0;
            debug_wb_pc <= 32'd0;
        end else if (grant_pipe) begin
            rf_wen_o    <= 1'b1;
            rf_waddr_o  <= wb_waddr_i;
            rf_wdata_o  <= wb_wdata_i;
            debug_wb_pc <= wb_pc_i;
        end else if (grant_lr) begin
            rf_wen_o    <= 1'b1;
            rf_waddr_o  <= lr_waddr_i;
            rf_wdata_o  <= lr_wdata_i;
            debug_wb_pc <= lr_pc_i;
        end else begin
            rf_wen_o    <= 1'b0;
        end
    end

    assign debug_wb_rf_wen   = {4{rf_wen_o}};
    assign debug_wb_rf_wnum  = rf_waddr_o;
    assign debug_wb_rf_wdata = rf_wdata_o;

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// tb/tb_rf_wport_arbiter.sv - directed self-checking bench for rf_wport_arbiter
module tb_rf_wport_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_wen_i = 1'b0;
    logic [4:0]  wb_waddr_i = '0;
    logic [31:0] wb_wdata_i = '0;
    logic [31:0] wb_pc_i = '0;
    logic        wb_stall_i = 1'b0;
    logic        wb_flush_i = 1'b0;
    logic        lr_valid_i = 1'b0;
    logic [4:0]  lr_waddr_i = '0;
    logic [31:0] lr_wdata_i = '0;
    logic [31:0] lr_pc_i = '0;
    logic        lr_ready_o;
    logic        arb_stall_o;
    logic        rf_wen_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    rf_wport_arbiter #(.STARVE_MAX(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .wb_wen_i          (wb_wen_i),
        .wb_waddr_i        (wb_waddr_i),
        .wb_wdata_i        (wb_wdata_i),
        .wb_pc_i           (wb_pc_i),
        .wb_stall_i        (wb_stall_i),
        .wb_flush_i        (wb_flush_i),
        .lr_valid_i        (lr_valid_i),
        .lr_waddr_i        (lr_waddr_i),
        .lr_wdata_i        (lr_wdata_i),
        .lr_pc_i           (lr_pc_i),
        .lr_ready_o        (lr_ready_o),
        .arb_stall_o       (arb_stall_o),
        .rf_wen_o          (rf_wen_o),
        .rf_waddr_o        (rf_waddr_o),
        .rf_wdata_o        (rf_wdata_o),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    // Registered outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wb(input logic wen, input logic [4:0] a, input logic [31:0] d,
                            input logic [31:0] pc, input logic stall, input logic flush);
        wb_wen_i = wen; wb_waddr_i = a; wb_wdata_i = d; wb_pc_i = pc;
        wb_stall_i = stall; wb_flush_i = flush;
    endtask

    task automatic drive_lr(input logic v, input logic [4:0] a, input logic [31:0] d,
                            input logic [31:0] pc);
        lr_valid_i = v; lr_waddr_i = a; lr_wdata_i = d; lr_pc_i = pc;
    endtask

    task automatic test_reset();
        #2;
        chk_cnt++; if (rf_wen_o !== 1'b0) $display("FAIL reset_wen got %b want 0", rf_wen_o); else pass_cnt++;
        chk_cnt++; if (debug_wb_pc !== 32'd0) $display("FAIL reset_pc got %h want 0", debug_wb_pc); else pass_cnt++;
        step();
        rst = 1'b1;
        drive_wb(1'b1, 5'd7, 32'hAAAA_5555, 32'h100, 1'b0, 1'b0);
        step();
        drive_wb(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        drive_lr(1'b1, 5'd3, 32'h77, 32'h200);
        chk_cnt++; if (rf_wen_o !== 1'b1) $display("FAIL pre_reset_write got %b want 1", rf_wen_o); else pass_cnt++;
        #2 rst = 1'b0;
        #1;
        chk_cnt++; if (rf_wen_o !== 1'b0) $display("FAIL async_reset_wen got %b want 0", rf_wen_o); else pass_cnt++;
        chk_cnt++; if (rf_waddr_o !== 5'd0) $display("FAIL async_reset_waddr got %0d want 0", rf_waddr_o); else pass_cnt++;
        chk_cnt++; if (rf_wdata_o !== 32'd0) $display("FAIL async_reset_wdata got %h want 0", rf_wdata_o); else pass_cnt++;
        chk_cnt++; if (debug_wb_pc !== 32'd0) $display("FAIL async_reset_pc got %h want 0", debug_wb_pc); else pass_cnt++;
        chk_cnt++; if (debug_wb_rf_wen !== 4'h0) $display("FAIL async_reset_dbg_wen got %h want 0", debug_wb_rf_wen); else pass_cnt++;
        chk_cnt++; if (lr_ready_o !== 1'b0) $display("FAIL async_reset_ready got %b want 0", lr_ready_o); else pass_cnt++;
        chk_cnt++; if (arb_stall_o !== 1'b0) $display("FAIL async_reset_stall got %b want 0", arb_stall_o); else pass_cnt++;
        step();
        rst = 1'b1;
        drive_lr(1'b0, 5'd0, 32'd0, 32'd0);
        drive_wb(1'b1, 5'd5, 32'h1234, 32'hBFC0_0000, 1'b0, 1'b0);
        step();
        drive_wb(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk_cnt++; if (rf_wen_o !== 1'b1) $display("FAIL first_grant_wen got %b want 1", rf_wen_o); else pass_cnt++;
        chk_cnt++; if (rf_waddr_o !== 5'd5) $display("FAIL first_grant_waddr got %0d want 5", rf_waddr_o); else pass_cnt++;
        chk_cnt++; if (rf_wdata_o !== 32'h1234) $display("FAIL first_grant_wdata got %h want 1234", rf_wdata_o); else pass_cnt++;
        chk_cnt++; if (debug_wb_rf_wen !== 4'hF) $display("FAIL first_grant_dbg_wen got %h want f", debug_wb_rf_wen); else pass_cnt++;
        chk_cnt++; if (debug_wb_rf_wnum !== 5'd5) $display("FAIL first_grant_dbg_wnum got %0d want 5", debug_wb_rf_wnum); else pass_cnt++;
        step();
    endtask

    task automatic test_pipe_only();
        for (int i = 1; i <= 3; i++) begin
            drive_wb(1'b1, 5'(i), 32'h1000 + 32'(i), 32'h400 + 32'(i * 4), 1'b0, 1'b0);
            #1;
            chk_cnt++; if (lr_ready_o !== 1'b0) $display("FAIL pipe_only_ready[%0d] got %b want 0", i, lr_ready_o); else pass_cnt++;
            step();
            chk_cnt++; if (rf_waddr_o !== 5'(i)) $display("FAIL pipe_only_waddr[%0d] got %0d want %0d", i, rf_waddr_o, i); else pass_cnt++;
            chk_cnt++; if (rf_wen_o !== 1'b1) $display("FAIL pipe_only_wen[%0d] got %b want 1", i, rf_wen_o); else pass_cnt++;
        end
        drive_wb(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        step();
        chk_cnt++; if (rf_wen_o !== 1'b0) $display("FAIL pipe_only_idle_wen got %b want 0", rf_wen_o); else pass_cnt++;
        chk_cnt++; if (rf_waddr_o !== 5'd3) $display("FAIL pipe_only_hold_waddr got %0d want 3", rf_waddr_o); else pass_cnt++;
    endtask

    task automatic test_lr_idle();
        drive_lr(1'b1, 5'd9, 32'hDEAD, 32'hBFC0_0100);
        #1;
        chk_cnt++; if (lr_ready_o !== 1'b1) $display("FAIL lr_idle_ready got %b want 1", lr_ready_o); else pass_cnt++;
        step();
        drive_lr(1'b0, 5'd0, 32'd0, 32'd0);
        chk_cnt++; if (rf_waddr_o !== 5'd9) $display("FAIL lr_idle_waddr got %0d want 9", rf_waddr_o); else pass_cnt++;
        chk_cnt++; if (rf_wdata_o !== 32'hDEAD) $display("FAIL lr_idle_wdata got %h want dead", rf_wdata_o); else pass_cnt++;
        chk_cnt++; if (debug_wb_pc !== 32'hBFC0_0100) $display("FAIL lr_idle_pc got %h want bfc00100", debug_wb_pc); else pass_cnt++;
        step();
        chk_cnt++; if (rf_wen_o !== 1'b0) $display("FAIL lr_idle_once got %b want 0", rf_wen_o); else pass_cnt++;
    endtask

    task automatic test_flush_stall();
        drive_wb(1'b1, 5'd11, 32'h11, 32'h500, 1'b0, 1'b1);
        step();
        chk_cnt++; if (rf_wen_o !== 1'b0) $display("FAIL flush_gate_wen got %b want 0", rf_wen_o); else pass_cnt++;
        drive_wb(1'b1, 5'd12, 32'h12, 32'h504, 1'b1, 1'b0);
        step();
        chk_cnt++; if (rf_wen_o !== 1'b0) $display("FAIL stall_gate_wen got %b want 0", rf_wen_o); else pass_cnt++;
        drive_wb(1'b1, 5'd13, 32'h13, 32'h508, 1'b0, 1'b1);
        drive_lr(1'b1, 5'd14, 32'hCAFE, 32'h600);
        #1;
        chk_cnt++; if (lr_ready_o !== 1'b1) $display("FAIL flush_lr_ready got %b want 1", lr_ready_o); else pass_cnt++;
        step();
        drive_wb(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        drive_lr(1'b0, 5'd0, 32'd0, 32'd0);
        chk_cnt++; if (rf_waddr_o !== 5'd14) $display("FAIL flush_lr_waddr got %0d want 14", rf_waddr_o); else pass_cnt++;
        step();
    endtask

`ifdef RF_ARB_STARVE_EN
    task automatic test_starvation();
        drive_lr(1'b1, 5'd20, 32'hBEEF, 32'h700);
        for (int i = 0; i < 4; i++) begin
            drive_wb(1'b1, 5'(10 + i), 32'h2000 + 32'(i), 32'h800 + 32'(i * 4), 1'b0, 1'b0);
            #1;
            chk_cnt++; if (arb_stall_o !== 1'b0) $display("FAIL starve_stall[%0d] got %b want 0", i, arb_stall_o); else pass_cnt++;
            chk_cnt++; if (lr_ready_o !== 1'b0) $display("FAIL starve_ready[%0d] got %b want 0", i, lr_ready_o); else pass_cnt++;
            step();
            chk_cnt++; if (rf_waddr_o !== 5'(10 + i)) $display("FAIL starve_pipe_waddr[%0d] got %0d want %0d", i, rf_waddr_o, 10 + i); else pass_cnt++;
        end
        drive_wb(1'b1, 5'd14, 32'h2004, 32'h810, 1'b0, 1'b0);
        #1;
        chk_cnt++; if (arb_stall_o !== 1'b1) $display("FAIL force_stall got %b want 1", arb_stall_o); else pass_cnt++;
        chk_cnt++; if (lr_ready_o !== 1'b1) $display("FAIL force_ready got %b want 1", lr_ready_o); else pass_cnt++;
        step();
        drive_lr(1'b0, 5'd0, 32'd0, 32'd0);
        chk_cnt++; if (rf_waddr_o !== 5'd20) $display("FAIL force_lr_waddr got %0d want 20", rf_waddr_o); else pass_cnt++;
        chk_cnt++; if (debug_wb_pc !== 32'h700) $display("FAIL force_lr_pc got %h want 700", debug_wb_pc); else pass_cnt++;
        chk_cnt++; if (arb_stall_o !== 1'b0) $display("FAIL resume_stall got %b want 0", arb_stall_o); else pass_cnt++;
        step();
        drive_wb(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk_cnt++; if (rf_waddr_o !== 5'd14) $display("FAIL resume_pipe_waddr got %0d want 14", rf_waddr_o); else pass_cnt++;
        step();
    endtask
`else
    task automatic test_strict_priority();
        drive_lr(1'b1, 5'd20, 32'hBEEF, 32'h700);
        for (int i = 0; i < 6; i++) begin
            drive_wb(1'b1, 5'(10 + i), 32'h2000 + 32'(i), 32'h800 + 32'(i * 4), 1'b0, 1'b0);
            #1;
            chk_cnt++; if (arb_stall_o !== 1'b0) $display("FAIL strict_stall[%0d] got %b want 0", i, arb_stall_o); else pass_cnt++;
            chk_cnt++; if (lr_ready_o !== 1'b0) $display("FAIL strict_ready[%0d] got %b want 0", i, lr_ready_o); else pass_cnt++;
            step();
            chk_cnt++; if (rf_waddr_o !== 5'(10 + i)) $display("FAIL strict_pipe_waddr[%0d] got %0d want %0d", i, rf_waddr_o, 10 + i); else pass_cnt++;
        end
        drive_wb(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        #1;
        chk_cnt++; if (lr_ready_o !== 1'b1) $display("FAIL strict_lr_ready got %b want 1", lr_ready_o); else pass_cnt++;
        step();
        drive_lr(1'b0, 5'd0, 32'd0, 32'd0);
        chk_cnt++; if (rf_waddr_o !== 5'd20) $display("FAIL strict_lr_waddr got %0d want 20", rf_waddr_o); else pass_cnt++;
        step();
    endtask
`endif

    task automatic test_back_to_back();
        drive_wb(1'b1, 5'd21, 32'h21, 32'h900, 1'b0, 1'b0);
        step();
        chk_cnt++; if (rf_waddr_o !== 5'd21 || rf_wen_o !== 1'b1) $display("FAIL b2b_pipe got wen=%b addr=%0d want wen=1 addr=21", rf_wen_o, rf_waddr_o); else pass_cnt++;
        drive_wb(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        drive_lr(1'b1, 5'd0, 32'h5A5A, 32'hA00);
        step();
        chk_cnt++; if (rf_waddr_o !== 5'd0 || rf_wen_o !== 1'b1) $display("FAIL b2b_lr_r0 got wen=%b addr=%0d want wen=1 addr=0", rf_wen_o, rf_waddr_o); else pass_cnt++;
        chk_cnt++; if (rf_wdata_o !== 32'h5A5A) $display("FAIL b2b_lr_r0_data got %h want 5a5a", rf_wdata_o); else pass_cnt++;
        drive_lr(1'b0, 5'd0, 32'd0, 32'd0);
        drive_wb(1'b1, 5'd22, 32'h22, 32'h904, 1'b0, 1'b0);
        step();
        drive_wb(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk_cnt++; if (rf_waddr_o !== 5'd22 || rf_wen_o !== 1'b1) $display("FAIL b2b_pipe2 got wen=%b addr=%0d want wen=1 addr=22", rf_wen_o, rf_waddr_o); else pass_cnt++;
        step();
    endtask

    initial begin
        test_reset();
        test_pipe_only();
        test_lr_idle();
        test_flush_stall();
`ifdef RF_ARB_STARVE_EN
        test_starvation();
`else
        test_strict_priority();
`endif
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
